ladder_ctrl: RTL
================

Name: ladder_ctrl

Overview:
Sequencing FSM for Montgomery-ladder modular exponentiation over one shared Montgomery multiplier. Steps the multiplier through one pre-conversion, two multiplications per exponent bit (MSB first) and one post-conversion. Drives operand selects, the multiplier start pulse and datapath register write-enables. Sits between the top-level exponentiation interface (start/done, in_e, lene) and the 1024-bit datapath/multiplier.

Parameters:
E_W, 1024, exponent register width in bits
IDX_W, 11, bit-index counter width; must satisfy 2^IDX_W > E_W

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
start  in  1  one-cycle request; accepted only in IDLE or DONE
in_e  in  E_W  exponent; sampled on accepted start
lene  in  32  exponent bit length; sampled on accepted start
mm_done  in  1  multiplier completion pulse, one cycle
mm_start  out  1  one-cycle multiplier start pulse
mm_a_sel  out  2  A operand: 00=X, 01=R0, 10=R1
mm_b_sel  out  2  B operand: 00=R2, 01=R0, 10=R1, 11=ONE
load  out  1  datapath captures x, m, r, r2 and sets R0<=r
wr_r0  out  1  write multiplier result into R0
wr_r1  out  1  write multiplier result into R1
wr_res  out  1  write multiplier result into result register
busy  out  1  high in every state except IDLE and DONE
done  out  1  level; high in DONE until the next accepted start

Behaviour:
- Reset: async; state=IDLE, all outputs 0, internal e/index/length cleared. Reset mid-operation aborts immediately, with no further write-enables.
- States: IDLE, LOAD, PRE_ISS, PRE_WAIT, MUL_ISS, MUL_WAIT, SQR_ISS, SQR_WAIT, POST_ISS, POST_WAIT, DONE.
- IDLE/DONE + start: latch in_e. Latch len = min(lene, E_W). Go to LOAD. done drops the next cycle.
- LOAD: load=1 for one cycle, idx=len-1 -> PRE_ISS.
- *_ISS: mm_start=1 for one cycle with selects set -> matching *_WAIT.
- *_WAIT: selects held stable. When mm_done=1, assert the destination write-enable for that same cycle and advance.
- Operation table:
  - PRE: A=X, B=R2 -> wr_r1.
  - MUL: A=R0, B=R1 -> wr_r0 if e[idx]=1, else wr_r1.
  - SQR: if e[idx]=1, A=R1, B=R1 -> wr_r1; else A=R0, B=R0 -> wr_r0.
  - POST: A=R0, B=ONE -> wr_res.
- Product before square: the square operand is never overwritten by the preceding product, so no temporary register is needed.
- After PRE_WAIT: len=0 -> POST_ISS; else -> MUL_ISS.
- After SQR_WAIT: idx=0 -> POST_ISS; else idx--, -> MUL_ISS.
- After POST_WAIT -> DONE.
- Selects and write-enables are 0 outside the states listed above. At most one write-enable is high per cycle.
- Latency, for a multiplier returning mm_done L>=1 cycles after mm_start:
  - N = 2*len+2 operations.
  - done rises 2+N*(L+1) cycles after the start cycle.
- Start while busy: ignored.
- mm_done outside a *_WAIT state: ignored.
- mm_done in the same cycle as mm_start (ISS state): ignored; the pulse is only honoured in WAIT.
- lene > E_W: saturates to E_W.
- Bits of in_e at index >= len are ignored.

Test Plan:
- lene=0, L=3 (behavioural multiplier model):
  - ops: PRE(a=00, b=00, wr_r1), then POST(a=01, b=11, wr_res).
  - done high exactly 10 cycles after start; busy high in cycles 1..9.
- in_e=0xEB, lene=8, L=5:
  - 18 ops; bit sequence 1,1,1,0,1,0,1,1.
  - bit=1 pair: (01,10,wr_r0), (10,10,wr_r1).
  - bit=0 pair: (01,10,wr_r1), (01,01,wr_r0).
  - done at cycle 110.
  - Full datapath with the standard 1024-bit test vector: result = 0x491240bb…f5de.
- Pulse start at cycle 20 of a run, and inject mm_done in IDLE and during an ISS cycle:
  - no state change and no extra mm_start or write-enable.
  - Cycle count unchanged.
- Assert resetn=0 during MUL_WAIT of bit 3:
  - all outputs 0 asynchronously.
  - After release, a new start with lene=2, L=1 completes in 2+6*2=14 cycles.
- lene=1100, E_W=1024, L=1:
  - 2050 mm_start pulses; first MUL uses in_e[1023].
  - done at 2+2050*2=4102.
- start asserted while in DONE:
  - done low the following cycle; load=1 that cycle.
  - The second run's op sequence matches a fresh run.

Source files
------------

// File: rtl/ladder_ctrl_if.sv
// Signal bundle between the exponentiation front end, the Montgomery-ladder
// sequencer and the shared Montgomery multiplier / datapath registers.
interface ladder_ctrl_if #(
   parameter int E_W = 1024
);
   logic           start;
   logic [E_W-1:0] in_e;
   logic [31:0]    lene;
   logic           mm_done;
   logic           mm_start;
   logic [1:0]     mm_a_sel;
   logic [1:0]     mm_b_sel;
   logic           load;
   logic           wr_r0;
   logic           wr_r1;
   logic           wr_res;
   logic           busy;
   logic           done;

   modport master (
      output start, in_e, lene, mm_done,
      input  mm_start, mm_a_sel, mm_b_sel, load, wr_r0, wr_r1, wr_res, busy, done
   );

   modport slave (
      input  start, in_e, lene, mm_done,
      output mm_start, mm_a_sel, mm_b_sel, load, wr_r0, wr_r1, wr_res, busy, done
   );
endinterface

// File: rtl/ladder_ctrl.sv
// Montgomery-ladder sequencer: one pre-conversion, product+square per exponent
// bit (MSB first) and one post-conversion on a single shared multiplier.
module ladder_ctrl #(
   parameter int E_W   = 1024,
   parameter int IDX_W = 11
) (
   input  logic         clk,
   input  logic         resetn,
   ladder_ctrl_if.slave bus
);
   typedef enum logic [3:0] {
      S_IDLE,
      S_LOAD,
      S_PRE_ISS,
      S_PRE_WAIT,
      S_MUL_ISS,
      S_MUL_WAIT,
      S_SQR_ISS,
      S_SQR_WAIT,
      S_POST_ISS,
      S_POST_WAIT,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [E_W-1:0]   r_e;
   logic [IDX_W-1:0] r_len;
   logic [IDX_W-1:0] r_idx;
   logic [IDX_W-1:0] w_len_sat;
   logic [IDX_W-1:0] w_shamt;
   logic             w_accept;
   logic             w_bit;

   assign w_accept  = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_len_sat = (bus.lene > 32'(E_W)) ? IDX_W'(E_W) : bus.lene[IDX_W-1:0];
   // Exponent is left-aligned on capture so the bit under test is always the MSB.
   assign w_shamt   = IDX_W'(E_W) - w_len_sat;
   assign w_bit     = r_e[E_W-1];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
         r_e     <= '0;
         r_len   <= '0;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_e   <= bus.in_e << w_shamt;
            r_len <= w_len_sat;
         end
         if (r_state == S_LOAD) begin
            r_idx <= r_len - IDX_W'(1);
         end
         if ((r_state == S_SQR_WAIT) && bus.mm_done) begin
            r_e <= r_e << 1;
            if (r_idx != '0) begin
               r_idx <= r_idx - IDX_W'(1);
            end
         end
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      bus.mm_start = 1'b0;
      bus.mm_a_sel = 2'b00;
      bus.mm_b_sel = 2'b00;
      bus.load     = 1'b0;
      bus.wr_r0    = 1'b0;
      bus.wr_r1    = 1'b0;
      bus.wr_res   = 1'b0;
      bus.done     = 1'b0;
      bus.busy     = (r_state != S_IDLE) && (r_state != S_DONE);

      unique case (r_state)
         S_IDLE: begin
            if (bus.start) w_state_nxt = S_LOAD;
         end
         S_DONE: begin
            bus.done = 1'b1;
            if (bus.start) w_state_nxt = S_LOAD;
         end
         S_LOAD: begin
            bus.load    = 1'b1;
            w_state_nxt = S_PRE_ISS;
         end
         S_PRE_ISS: begin
            bus.mm_start = 1'b1;
            w_state_nxt  = S_PRE_WAIT;
         end
         S_PRE_WAIT: begin
            if (bus.mm_done) begin
               bus.wr_r1   = 1'b1;
               w_state_nxt = (r_len == '0) ? S_POST_ISS : S_MUL_ISS;
            end
         end
         S_MUL_ISS, S_MUL_WAIT: begin
            bus.mm_a_sel = 2'b01;
            bus.mm_b_sel = 2'b10;
            if (r_state == S_MUL_ISS) begin
               bus.mm_start = 1'b1;
               w_state_nxt  = S_MUL_WAIT;
            end else if (bus.mm_done) begin
               bus.wr_r0   = w_bit;
               bus.wr_r1   = !w_bit;
               w_state_nxt = S_SQR_ISS;
            end
         end
         S_SQR_ISS, S_SQR_WAIT: begin
            bus.mm_a_sel = w_bit ? 2'b10 : 2'b01;
            bus.mm_b_sel = w_bit ? 2'b10 : 2'b01;
            if (r_state == S_SQR_ISS) begin
               bus.mm_start = 1'b1;
               w_state_nxt  = S_SQR_WAIT;
            end else if (bus.mm_done) begin
               bus.wr_r1   = w_bit;
               bus.wr_r0   = !w_bit;
               w_state_nxt = (r_idx == '0) ? S_POST_ISS : S_MUL_ISS;
            end
         end
         S_POST_ISS, S_POST_WAIT: begin
            bus.mm_a_sel = 2'b01;
            bus.mm_b_sel = 2'b11;
            if (r_state == S_POST_ISS) begin
               bus.mm_start = 1'b1;
               w_state_nxt  = S_POST_WAIT;
            end else if (bus.mm_done) begin
               bus.wr_res  = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end
endmodule
